// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer that shares one ALU between two requesters.
// One operation is in flight at a time: IDLE (grant/latch) -> EXEC (evaluate) -> RESP (hold).
module alu_share_ctrl #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_op0,
    input  logic [3:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_err,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    localparam int unsigned Msb = WIDTH - 1;

    localparam logic [3:0] OpAnd  = 4'd0;
    localparam logic [3:0] OpOr   = 4'd1;
    localparam logic [3:0] OpAdd  = 4'd2;
    localparam logic [3:0] OpSub  = 4'd6;
    localparam logic [3:0] OpSlt  = 4'd7;
    localparam logic [3:0] OpNor  = 4'd12;
    localparam logic [3:0] OpNand = 4'd13;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic             r_id;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic             r_rsp_overflow;
    logic             r_rsp_err;
    logic [CNT_W-1:0] r_done_cnt0;
    logic [CNT_W-1:0] r_done_cnt1;

    logic             w_grant_valid;
    logic             w_grant_id;
    logic             w_hs;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic             w_alu_err;

    // Grant selection: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        w_grant_valid = |req_valid;
        w_grant_id    = 1'b0;
        case (req_valid)
            2'b01:   w_grant_id = 1'b0;
            2'b10:   w_grant_id = 1'b1;
            2'b11:   w_grant_id = ~r_last_grant;
            default: w_grant_id = 1'b0;
        endcase
        req_ready = 2'b00;
        if (r_state == StIdle && w_grant_valid) begin
            req_ready[w_grant_id] = 1'b1;
        end
        w_hs = |(req_valid & req_ready);
    end

    // ALU evaluation of the latched operands; overflow comes from operand/result sign bits.
    always_comb begin
        w_sum     = r_a + r_b;
        w_diff    = r_a - r_b;
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        w_alu_err = 1'b0;
        case (r_op)
            OpAnd:  w_alu_res = r_a & r_b;
            OpOr:   w_alu_res = r_a | r_b;
            OpAdd: begin
                w_alu_res = w_sum;
                w_alu_ovf = (r_a[Msb] == r_b[Msb]) && (w_sum[Msb] != r_a[Msb]);
            end
            OpSub: begin
                w_alu_res = w_diff;
                w_alu_ovf = (r_a[Msb] != r_b[Msb]) && (w_diff[Msb] != r_a[Msb]);
            end
            OpSlt:  w_alu_res = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
            OpNor:  w_alu_res = ~(r_a | r_b);
            OpNand: w_alu_res = ~(r_a & r_b);
            default: w_alu_err = 1'b1;
        endcase
    end

    // Sequencer FSM with registered response fields and saturating completion counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= StIdle;
            r_last_grant   <= 1'b1;
            r_id           <= 1'b0;
            r_op           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_zero     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_err      <= 1'b0;
            r_done_cnt0    <= '0;
            r_done_cnt1    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_hs) begin
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_op         <= w_grant_id ? req_op1 : req_op0;
                        r_a          <= w_grant_id ? req_a1 : req_a0;
                        r_b          <= w_grant_id ? req_b1 : req_b0;
                        r_state      <= StExec;
                    end
                end
                StExec: begin
                    r_rsp_result   <= w_alu_res;
                    r_rsp_zero     <= !w_alu_err && (w_alu_res == '0);
                    r_rsp_overflow <= w_alu_ovf;
                    r_rsp_err      <= w_alu_err;
                    r_rsp_id       <= r_id;
                    r_rsp_valid    <= 1'b1;
                    r_state        <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                        if (!r_rsp_id) begin
                            if (r_done_cnt0 != '1) r_done_cnt0 <= r_done_cnt0 + 1'b1;
                        end else begin
                            if (r_done_cnt1 != '1) r_done_cnt1 <= r_done_cnt1 + 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_err      = r_rsp_err;
    assign done_cnt0    = r_done_cnt0;
    assign done_cnt1    = r_done_cnt1;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: transaction-level model checked every cycle, plus directed literals.
module tb_alu_share_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op0, req_op1;
    logic [63:0] req_a0, req_a1, req_b0, req_b1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_result;
    logic        rsp_zero, rsp_overflow, rsp_err;
    logic [31:0] done_cnt0, done_cnt1;

    alu_share_ctrl #(.WIDTH(64), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .rsp_err(rsp_err), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        id;
        logic [63:0] res;
        logic        z;
        logic        o;
        logic        e;
    } rsp_t;

    int   n_chk  = 0;
    int   n_pass = 0;
    rsp_t log_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // What the ALU must return for one request, straight from the opcode table.
    function automatic rsp_t alu_model(input logic id, input logic [3:0] op,
                                       input logic [63:0] a, input logic [63:0] b);
        rsp_t r;
        logic signed [64:0] s;
        r    = '0;
        r.id = id;
        case (op)
            4'd0:  r.res = a & b;
            4'd1:  r.res = a | b;
            4'd2: begin
                s     = $signed({a[63], a}) + $signed({b[63], b});
                r.res = s[63:0];
                r.o   = s[64] != s[63];
            end
            4'd6: begin
                s     = $signed({a[63], a}) - $signed({b[63], b});
                r.res = s[63:0];
                r.o   = s[64] != s[63];
            end
            4'd7:  r.res = (a < b) ? 64'd1 : 64'd0;
            4'd12: r.res = ~(a | b);
            4'd13: r.res = ~(a & b);
            default: begin
                r.res = '0;
                r.e   = 1'b1;
            end
        endcase
        r.z = !r.e && (r.res == 64'd0);
        return r;
    endfunction

    function automatic logic pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) return ~last;
        return v[1];
    endfunction

    // Model state: one outstanding transaction and its age in cycles since acceptance.
    logic        m_armed = 1'b0;
    logic        m_busy  = 1'b0;
    int          m_age   = 0;
    logic        m_last  = 1'b1;
    logic [31:0] m_cnt0  = '0;
    logic [31:0] m_cnt1  = '0;
    rsp_t        m_exp   = '0;
    logic [1:0]  exp_ready;
    logic        g;

    always @(negedge clk) begin
        if (m_armed) begin
            exp_ready = 2'b00;
            if (!m_busy && req_valid != 2'b00) exp_ready[pick(req_valid, m_last)] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_busy && m_age >= 1));
            chk("done_cnt0", 64'(done_cnt0), 64'(m_cnt0));
            chk("done_cnt1", 64'(done_cnt1), 64'(m_cnt1));
            if (m_busy && m_age >= 1) begin
                chk("rsp_id", 64'(rsp_id), 64'(m_exp.id));
                chk("rsp_result", rsp_result, m_exp.res);
                chk("rsp_zero", 64'(rsp_zero), 64'(m_exp.z));
                chk("rsp_overflow", 64'(rsp_overflow), 64'(m_exp.o));
                chk("rsp_err", 64'(rsp_err), 64'(m_exp.e));
            end
            if (reset_n && rsp_valid && rsp_ready)
                log_q.push_back('{rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_err});
        end
        if (!reset_n) begin
            m_armed = 1'b1;
            m_busy  = 1'b0;
            m_age   = 0;
            m_last  = 1'b1;
            m_cnt0  = '0;
            m_cnt1  = '0;
        end else if (m_busy) begin
            if (m_age >= 1 && rsp_ready) begin
                if (!m_exp.id) begin
                    if (m_cnt0 != '1) m_cnt0 = m_cnt0 + 1;
                end else begin
                    if (m_cnt1 != '1) m_cnt1 = m_cnt1 + 1;
                end
                m_busy = 1'b0;
            end else begin
                m_age = m_age + 1;
            end
        end else if (req_valid != 2'b00) begin
            g      = pick(req_valid, m_last);
            m_exp  = g ? alu_model(1'b1, req_op1, req_a1, req_b1)
                       : alu_model(1'b0, req_op0, req_a0, req_b0);
            m_last = g;
            m_busy = 1'b1;
            m_age  = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run until n more responses complete, dropping each requester's valid once accepted.
    task automatic serve(input int n);
        int          start;
        int          cyc;
        logic [1:0]  hs;
        start = log_q.size();
        cyc   = 0;
        while (log_q.size() < start + n && cyc < 60) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            tick();
            req_valid = req_valid & ~hs;
            cyc++;
        end
        chk("serve_timeout", 64'(log_q.size()), 64'(start + n));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    int base;

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        req_op0 = '0; req_op1 = '0;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_cnt0", 64'(done_cnt0), 64'd0);

        // Single ADD from port 0: response two cycles after the handshake.
        req_op0 = 4'd2; req_a0 = 64'd5; req_b0 = 64'd7; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        chk("lat_exec_valid", 64'(rsp_valid), 64'd0);
        tick();
        chk("lat_resp_valid", 64'(rsp_valid), 64'd1);
        chk("add_result", rsp_result, 64'd12);
        chk("add_id", 64'(rsp_id), 64'd0);
        tick();
        chk("add_cnt0", 64'(done_cnt0), 64'd1);
        chk("add_valid_drop", 64'(rsp_valid), 64'd0);

        // Contention after reset: port 0 first, then alternating.
        do_reset();
        req_op0 = 4'd0; req_a0 = 64'hFF; req_b0 = 64'h0F;
        req_op1 = 4'd6; req_a1 = 64'd3;  req_b1 = 64'd3;
        base = log_q.size();
        req_valid = 2'b11;
        serve(2);
        chk("rr1_id", 64'(log_q[base].id), 64'd0);
        chk("rr1_res", log_q[base].res, 64'h0F);
        chk("rr2_id", 64'(log_q[base+1].id), 64'd1);
        chk("rr2_res", log_q[base+1].res, 64'd0);
        chk("rr2_zero", 64'(log_q[base+1].z), 64'd1);
        base = log_q.size();
        req_valid = 2'b11;
        serve(2);
        chk("rr3_id", 64'(log_q[base].id), 64'd0);
        chk("rr4_id", 64'(log_q[base+1].id), 64'd1);

        // Overflow corners and unsigned compare.
        base = log_q.size();
        req_op0 = 4'd2; req_a0 = 64'h7FFF_FFFF_FFFF_FFFF; req_b0 = 64'd1; req_valid = 2'b01;
        serve(1);
        req_op0 = 4'd6; req_a0 = 64'h8000_0000_0000_0000; req_b0 = 64'd1; req_valid = 2'b01;
        serve(1);
        req_op0 = 4'd7; req_a0 = 64'd1; req_b0 = 64'd2; req_valid = 2'b01;
        serve(1);
        chk("addov_res", log_q[base].res, 64'h8000_0000_0000_0000);
        chk("addov_ovf", 64'(log_q[base].o), 64'd1);
        chk("subov_res", log_q[base+1].res, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("subov_ovf", 64'(log_q[base+1].o), 64'd1);
        chk("slt_res", log_q[base+2].res, 64'd1);
        chk("slt_ovf", 64'(log_q[base+2].o), 64'd0);

        // Backpressure: response held for 5 cycles with both requesters waiting.
        rsp_ready = 1'b0;
        req_op0 = 4'd2; req_a0 = 64'd10; req_b0 = 64'd20; req_valid = 2'b01;
        tick();
        req_valid = 2'b11;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_ready", 64'(req_ready), 64'd0);
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_result", rsp_result, 64'd30);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        tick();
        chk("stall_cnt0", 64'(done_cnt0), 64'd6);
        chk("stall_valid_drop", 64'(rsp_valid), 64'd0);

        // Illegal opcode from port 1.
        base = log_q.size();
        req_op1 = 4'd3; req_a1 = 64'd9; req_b1 = 64'd4; req_valid = 2'b10;
        serve(1);
        chk("ill_err", 64'(log_q[base].e), 64'd1);
        chk("ill_res", log_q[base].res, 64'd0);
        chk("ill_zero", 64'(log_q[base].z), 64'd0);
        chk("ill_id", 64'(log_q[base].id), 64'd1);
        chk("ill_cnt1", 64'(done_cnt1), 64'd3);

        // Reset while the operation is executing discards it.
        req_op0 = 4'd2; req_a0 = 64'd1; req_b0 = 64'd1; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        reset_n   = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rst_no_valid", 64'(rsp_valid), 64'd0);
            tick();
        end
        chk("rst_cnt0", 64'(done_cnt0), 64'd0);
        chk("rst_cnt1", 64'(done_cnt1), 64'd0);
        base = log_q.size();
        req_op0 = 4'd1;  req_a0 = 64'd1; req_b0 = 64'd2;
        req_op1 = 4'd12; req_a1 = 64'd0; req_b1 = 64'd0;
        req_valid = 2'b11;
        serve(2);
        chk("rst_first_id", 64'(log_q[base].id), 64'd0);
        chk("rst_or_res", log_q[base].res, 64'd3);
        chk("rst_second_id", 64'(log_q[base+1].id), 64'd1);
        chk("rst_nor_res", log_q[base+1].res, 64'hFFFF_FFFF_FFFF_FFFF);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
